// File: rtl/mac_stream_engine.sv
// Streaming keyed MAC: absorbs DATA_W-bit chunks lane by lane over valid/ready,
// then folds in the chunk count and emits a MAC_W-bit tag with a one-cycle pulse.
module mac_stream_engine #(
    parameter int                DATA_W = 256,
    parameter int                MAC_W  = 8,
    parameter int                ROT    = 1,
    parameter logic [MAC_W-1:0]  IV     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MAC_W-1:0]  key,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [MAC_W-1:0]  mac,
    output logic              mac_valid,
    output logic              busy
);

    localparam int NLANE = DATA_W / MAC_W;
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABSORB,
        S_FINAL
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_chunk;
    logic [LW-1:0]      r_lane;
    logic               r_last;
    logic [MAC_W-1:0]   r_acc;
    logic [MAC_W-1:0]   r_cnt;
    logic [MAC_W-1:0]   r_key;
    logic               r_first;
    logic [MAC_W-1:0]   r_mac;
    logic               r_mac_valid;

    logic               w_hs;
    logic               w_lane_end;
    logic [MAC_W-1:0]   w_lane;
    logic [MAC_W-1:0]   w_step;
    logic [MAC_W-1:0]   w_fin;

    function automatic logic [MAC_W-1:0] rotl(input logic [MAC_W-1:0] x);
        return (x << ROT) | (x >> (MAC_W - ROT));
    endfunction

    // The chunk register shifts down each step, so the current lane is always at the bottom.
    assign w_lane     = r_chunk[MAC_W-1:0];
    assign w_step     = rotl(r_acc ^ w_lane) + r_key;
    assign w_fin      = rotl(r_acc ^ r_cnt) + r_key;
    assign w_lane_end = (r_lane == LW'(NLANE - 1));

    assign in_ready  = (r_state != S_ABSORB);
    assign w_hs      = in_valid && in_ready;
    assign mac       = r_mac;
    assign mac_valid = r_mac_valid;
    assign busy      = (r_state != S_IDLE) || !r_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs) w_next = S_ABSORB;
            end
            S_ABSORB: begin
                if (w_lane_end) w_next = r_last ? S_FINAL : S_IDLE;
            end
            S_FINAL: begin
                w_next = w_hs ? S_ABSORB : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chunk     <= '0;
            r_lane      <= '0;
            r_last      <= 1'b0;
            r_acc       <= IV;
            r_cnt       <= '0;
            r_key       <= '0;
            r_first     <= 1'b1;
            r_mac       <= '0;
            r_mac_valid <= 1'b0;
        end else begin
            r_mac_valid <= 1'b0;
            unique case (r_state)
                S_ABSORB: begin
                    r_acc   <= w_step;
                    r_chunk <= r_chunk >> MAC_W;
                    r_lane  <= r_lane + 1'b1;
                end
                S_FINAL: begin
                    r_mac       <= w_fin;
                    r_mac_valid <= 1'b1;
                    r_acc       <= IV;
                    r_cnt       <= '0;
                    r_first     <= 1'b1;
                end
                default: ;
            endcase
            // A chunk taken during FINAL opens a fresh message.
            if (w_hs) begin
                r_chunk <= in_data;
                r_last  <= in_last;
                r_lane  <= '0;
                r_cnt   <= ((r_state == S_FINAL) ? '0 : r_cnt) + 1'b1;
                if (r_first || (r_state == S_FINAL)) begin
                    r_key   <= key;
                    r_acc   <= IV;
                    r_first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_engine.sv
// Directed bench for mac_stream_engine with DATA_W=16, MAC_W=8, ROT=1, IV=0.
module tb_mac_stream_engine;

    logic        clk;
    logic        rst_n;
    logic [7:0]  key;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [7:0]  mac;
    logic        mac_valid;
    logic        busy;

    int total;
    int bad;
    int pulses;

    mac_stream_engine #(
        .DATA_W (16),
        .MAC_W  (8),
        .ROT    (1),
        .IV     (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mac       (mac),
        .mac_valid (mac_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mac_valid === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_chunk(input logic [15:0] d, input logic l,
                              input logic [7:0] k);
        in_data  = d;
        in_last  = l;
        key      = k;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_mac(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 20 && !mac_valid; i++) tick();
        check({tag, "_valid"}, {31'd0, mac_valid}, 32'd1);
        check(tag, {24'd0, mac}, {24'd0, exp});
    endtask

    initial begin
        int p0;
        int hs;
        int hs_at[$];

        total    = 0;
        bad      = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        key      = 8'h00;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        in_last  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mac", {24'd0, mac}, 32'h00);
        check("rst_mac_valid", {31'd0, mac_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Single chunk, cycle-exact
        send_chunk(16'h0302, 1'b1, 8'h01);
        check("t1_rdy_c1", {31'd0, in_ready}, 32'd0);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("t1_rdy_c2", {31'd0, in_ready}, 32'd0);
        tick();
        check("t1_rdy_c3", {31'd0, in_ready}, 32'd1);
        check("t1_mv_c3", {31'd0, mac_valid}, 32'd0);
        tick();
        check("t1_mv_c4", {31'd0, mac_valid}, 32'd1);
        check("t1_mac", {24'd0, mac}, 32'h19);
        check("t1_busy_c4", {31'd0, busy}, 32'd0);
        tick();
        check("t1_mv_c5", {31'd0, mac_valid}, 32'd0);
        check("t1_mac_hold", {24'd0, mac}, 32'h19);

        // Two zero chunks exercise the count term
        send_chunk(16'h0000, 1'b0, 8'h00);
        tick();
        tick();
        check("t2_open_rdy", {31'd0, in_ready}, 32'd1);
        check("t2_open_busy", {31'd0, busy}, 32'd1);
        send_chunk(16'h0000, 1'b1, 8'h00);
        wait_mac("t2_mac", 8'h04);

        // Key sampled only on the first chunk
        send_chunk(16'h0000, 1'b0, 8'h01);
        send_chunk(16'h0000, 1'b1, 8'hAA);
        wait_mac("t3_mac", 8'h1B);
        tick();

        // Stall: in_valid held high
        p0       = pulses;
        hs       = 0;
        in_data  = 16'h0302;
        in_last  = 1'b1;
        key      = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready) begin
                hs++;
                hs_at.push_back(i);
            end
            tick();
            if (mac_valid) check("t4_mac", {24'd0, mac}, 32'h19);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mac_valid) check("t4_mac_tail", {24'd0, mac}, 32'h19);
        end
        check("t4_handshakes", hs, 32'd3);
        if (hs_at.size() >= 2)
            check("t4_spacing", hs_at[1] - hs_at[0], 32'd3);
        check("t4_pulses", pulses - p0, 32'd3);

        // Reset mid-absorb
        send_chunk(16'h0302, 1'b1, 8'h01);
        rst_n = 1'b0;
        #1;
        check("t5_mac", {24'd0, mac}, 32'h00);
        check("t5_mac_valid", {31'd0, mac_valid}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        #1 rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 6; i++) tick();
        check("t5_no_tag", pulses - p0, 32'd0);
        send_chunk(16'h0302, 1'b1, 8'h01);
        wait_mac("t5_resend", 8'h19);
        tick();

        // Count wrap: 256 zero chunks
        p0 = pulses;
        for (int n = 0; n < 256; n++)
            send_chunk(16'h0000, (n == 255), 8'h00);
        check("t6_early_pulse", pulses - p0, 32'd0);
        wait_mac("t6_mac", 8'h00);
        tick();
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_pulses", pulses - p0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
